bcd_seg_scan: RTL and testbench

Two-digit, time-multiplexed seven-segment display driver that consumes the tens/units BCD pair produced by the binary-to-BCD converter. It accepts a new BCD value over a valid/ready handshake into a one-deep pending register. It commits the value to the display only at a frame boundary, so a frame never shows one old and one new digit. It scans the units and tens digits alternately, with a one-cycle anti-ghosting blank at the start of each digit slot, optional leading-zero blanking and an error indication for invalid BCD.

---
 rtl/bcd_seg_scan.sv | 142 ++++++++++++++
 tb/tb_bcd_seg_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed seven-segment driver for a tens/units BCD pair.
// New values wait in a one-deep pending register and are shown only from the next frame.
module bcd_seg_scan #(
  parameter int unsigned REFRESH_DIV   = 4,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_tens,
  input  logic [3:0] in_units,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       err
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef struct packed {
    logic       tens;
    logic [3:0] units;
  } bcd_t;

  typedef enum logic {
    SCAN_U = 1'b0,
    SCAN_T = 1'b1
  } scan_t;

  scan_t         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bcd_t          shadow_q, shadow_d;
  bcd_t          pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic          ready_d;
  logic [6:0]    seg_d;
  logic [1:0]    dig_en_d;
  logic          err_d;

  logic          accept_c;
  logic          slot_end_c;
  logic          boundary_c;
  logic          bad_c;
  logic          tens_blank_c;
  logic [3:0]    digit_c;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCAN_U;
      cnt_q       <= '0;
      shadow_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      in_ready    <= 1'b0;
      seg         <= 7'h00;
      dig_en      <= 2'b00;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      in_ready    <= ready_d;
      seg         <= seg_d;
      dig_en      <= dig_en_d;
      err         <= err_d;
    end
  end

  // Scan sequencing, handshake, frame-boundary commit and next outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    accept_c   = in_valid && in_ready;
    slot_end_c = (cnt_q == CW'(REFRESH_DIV - 1));
    boundary_c = (state_q == SCAN_T) && slot_end_c;

    if (slot_end_c) begin
      cnt_d   = '0;
      state_d = (state_q == SCAN_U) ? SCAN_T : SCAN_U;
    end

    // Commit uses the pre-edge pending contents; a same-edge accept refills it.
    if (boundary_c && pend_full_q) begin
      shadow_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept_c) begin
      pend_d      = '{tens: in_tens, units: in_units};
      pend_full_d = 1'b1;
    end
    ready_d = !pend_full_d;

    bad_c        = (shadow_q.units > 4'd9);
    tens_blank_c = BLANK_LEADING && (state_q == SCAN_T) && !shadow_q.tens && !bad_c;
    digit_c      = (state_q == SCAN_T) ? {3'b000, shadow_q.tens} : shadow_q.units;

    if (bad_c) begin
      seg_d = 7'h40;
    end else if (tens_blank_c) begin
      seg_d = 7'h00;
    end else begin
      seg_d = seg_pattern(digit_c);
    end

    // Guard cycle at slot start keeps the previous digit from ghosting.
    if ((cnt_q == '0) || tens_blank_c) begin
      dig_en_d = 2'b00;
    end else if (state_q == SCAN_T) begin
      dig_en_d = 2'b10;
    end else begin
      dig_en_d = 2'b01;
    end

    err_d = bad_c;
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan with REFRESH_DIV=4, BLANK_LEADING=1.
// Edge numbering: edge 0 is the first rising edge after rst_n is released.
module tb_bcd_seg_scan;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_tens;
  logic [3:0] in_units;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       err;

  int n_chk;
  int n_pass;
  int e;

  bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tens  (in_tens),
    .in_units (in_units),
    .seg      (seg),
    .dig_en   (dig_en),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
  endtask

  // Advance one edge and sample 1ns later; dig_en must never be 11.
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    if (dig_en == 2'b11) chk("onehot", 32'(dig_en), 32'(2'b01));
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dig", 32'(dig_en), 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    e     = -1;
  endtask

  task automatic offer(input logic t, input logic [3:0] u);
    in_valid = 1'b1;
    in_tens  = t;
    in_units = u;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] d, input logic [6:0] s);
    chk({tag, "_dig"}, 32'(dig_en), 32'(d));
    chk({tag, "_seg"}, 32'(seg), 32'(s));
  endtask

  int acc_edges[$];
  logic acc;

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    e        = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_tens  = 1'b0;
    in_units = 4'd0;

    // Idle display of 0 with leading zero blanked
    do_reset();
    run_to(0);
    chk("a_rdy0", 32'(in_ready), 32'h1);
    expect_out("a_e0", 2'b00, 7'h3F);
    run_to(1); expect_out("a_e1", 2'b01, 7'h3F);
    run_to(4); expect_out("a_e4", 2'b00, 7'h00);
    run_to(5); expect_out("a_e5", 2'b00, 7'h00);
    run_to(7); expect_out("a_e7", 2'b00, 7'h00);
    run_to(9); expect_out("a_e9", 2'b01, 7'h3F);
    chk("a_err", 32'(err), 32'h0);

    // Accept 1/7 at edge 2, commit at edge 7
    do_reset();
    run_to(1);
    offer(1'b1, 4'd7);
    tick();
    in_valid = 1'b0;
    chk("b_rdy2", 32'(in_ready), 32'h0);
    run_to(6);  chk("b_rdy6", 32'(in_ready), 32'h0);
    run_to(7);  chk("b_rdy7", 32'(in_ready), 32'h1);
    run_to(8);  expect_out("b_e8", 2'b00, 7'h07);
    run_to(9);  expect_out("b_e9", 2'b01, 7'h07);
    run_to(12); expect_out("b_e12", 2'b00, 7'h06);
    run_to(13); expect_out("b_e13", 2'b10, 7'h06);

    // Accept on a boundary edge with pending empty: commits one frame later
    do_reset();
    run_to(6);
    offer(1'b0, 4'd5);
    tick();
    in_valid = 1'b0;
    chk("c_rdy7", 32'(in_ready), 32'h0);
    run_to(8);  expect_out("c_e8", 2'b00, 7'h3F);
    run_to(14); chk("c_rdy14", 32'(in_ready), 32'h0);
    run_to(15); chk("c_rdy15", 32'(in_ready), 32'h1);
    run_to(16); expect_out("c_e16", 2'b00, 7'h6D);
    run_to(17); expect_out("c_e17", 2'b01, 7'h6D);
    run_to(20); expect_out("c_e20", 2'b00, 7'h00);
    run_to(21); expect_out("c_e21", 2'b00, 7'h00);

    // Invalid units shows dashes in both slots, then a legal value clears err
    do_reset();
    run_to(0);
    offer(1'b0, 4'd12);
    tick();
    in_valid = 1'b0;
    run_to(8);
    chk("d_err8", 32'(err), 32'h1);
    expect_out("d_e8", 2'b00, 7'h40);
    offer(1'b0, 4'd4);
    tick();
    in_valid = 1'b0;
    expect_out("d_e9", 2'b01, 7'h40);
    run_to(13); expect_out("d_e13", 2'b10, 7'h40);
    run_to(15); chk("d_err15", 32'(err), 32'h1);
    run_to(16);
    chk("d_err16", 32'(err), 32'h0);
    expect_out("d_e16", 2'b00, 7'h66);
    run_to(17); expect_out("d_e17", 2'b01, 7'h66);
    run_to(21); expect_out("d_e21", 2'b00, 7'h00);

    // Upstream always valid, alternating 0/3 and 1/5: one accept per frame
    do_reset();
    offer(1'b0, 4'd3);
    acc_edges.delete();
    while (e < 31) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        acc_edges.push_back(e);
        if (in_tens) begin in_tens = 1'b0; in_units = 4'd3; end
        else         begin in_tens = 1'b1; in_units = 4'd5; end
      end
      if (e == 8)  expect_out("e_e8", 2'b00, 7'h4F);
      if (e == 13) expect_out("e_e13", 2'b00, 7'h00);
      if (e == 16) expect_out("e_e16", 2'b00, 7'h6D);
      if (e == 21) expect_out("e_e21", 2'b10, 7'h06);
      if (e == 24) expect_out("e_e24", 2'b00, 7'h4F);
    end
    in_valid = 1'b0;
    chk("e_nacc", 32'(acc_edges.size()), 32'd4);
    if (acc_edges.size() == 4) begin
      chk("e_acc0", 32'(acc_edges[0]), 32'd1);
      chk("e_acc1", 32'(acc_edges[1]), 32'd8);
      chk("e_acc2", 32'(acc_edges[2]), 32'd16);
      chk("e_acc3", 32'(acc_edges[3]), 32'd24);
    end

    // Reset mid-scan with pending full discards the pending value
    do_reset();
    run_to(0);
    offer(1'b1, 4'd9);
    tick();
    in_valid = 1'b0;
    run_to(3);
    chk("f_rdy3", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    tick();
    expect_out("f_rst", 2'b00, 7'h00);
    chk("f_rst_rdy", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    e     = -1;
    run_to(0);  chk("f_rdy0", 32'(in_ready), 32'h1);
    run_to(8);  expect_out("f_e8", 2'b00, 7'h3F);
    run_to(9);  expect_out("f_e9", 2'b01, 7'h3F);
    run_to(13); expect_out("f_e13", 2'b00, 7'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
